seq_cmp_ctrl: RTL and testbench
===============================

SEQ_CMP_CTRL -- requirements
Module: seq_cmp_ctrl

Interface
REQ-001 SHALL have parameter W, default 3, giving the operand width in bits (W >= 1).
REQ-002 SHALL have parameter CW, default 2, giving the width of the cycles count (CW = clog2(W+1)).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port start  input  1  request to begin comparing x against y.
REQ-006 SHALL have port abort  input  1  cancels a comparison in progress.
REQ-007 SHALL have port x  input  W  first operand, unsigned.
REQ-008 SHALL have port y  input  W  second operand, unsigned.
REQ-009 SHALL have port busy  output  1  high while a comparison is in progress (state SHIFT).
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid result on o.
REQ-011 SHALL have port o  output  3  result as {gt, eq, lt}: 100 = x>y, 010 = x==y, 001 = x<y.
REQ-012 SHALL have port cycles  output  CW  number of bit positions examined by the last completed comparison.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-014 SHALL accept start only in IDLE or DONE, with abort low; on acceptance it SHALL latch x and y, set bit index to W-1 and enter SHIFT.
REQ-015 SHALL ignore start while in SHIFT; the latched operands stay unchanged.
REQ-016 SHALL, in SHIFT, compare exactly one bit pair per cycle, MSB first, at the current index, using a 1-bit greater/equal/less relation.
REQ-017 SHALL, when the bits at the index differ, record gt or lt accordingly and enter DONE (early exit); the remaining bits are not examined.
REQ-018 SHALL, when the bits at the index are equal and the index is 0, record eq (010) and enter DONE.
REQ-019 SHALL, when the bits at the index are equal and the index is above 0, decrement the index and remain in SHIFT.
REQ-020 SHALL update o and cycles on the same edge that enters DONE; cycles = k, where k is the number of bits examined (1..W).
REQ-021 SHALL assert done for exactly the one cycle spent in DONE; done SHALL then return to 0.
REQ-022 SHALL hold o and cycles stable from DONE until the next result is written, including through IDLE and a new SHIFT.
REQ-023 SHALL give a latency of k cycles: start is sampled at edge E0 and done is high in the cycle following edge Ek.
REQ-024 SHALL, on start accepted in DONE, enter SHIFT at the next edge, allowing back-to-back comparisons with no IDLE cycle.
REQ-025 SHALL, when DONE is not followed by an accepted start, go to IDLE.
REQ-026 SHALL, on abort in SHIFT, go to IDLE, leave o and cycles unchanged, and not assert done.
REQ-027 SHALL give abort priority when abort and start are high in the same cycle: start is ignored and the FSM goes to (or stays in) IDLE.
REQ-028 SHALL give abort no effect in IDLE; in DONE the done pulse still completes and the FSM goes to IDLE.
REQ-029 SHALL hold o at exactly one-hot or 000, never any other code.

Reset
REQ-030 SHALL, with rst high at a clock edge, set state to IDLE, busy=0, done=0, o=000, cycles=0 and clear the latched operands and index.
REQ-031 SHALL give rst priority over start and abort, including mid-comparison; an aborted run SHALL produce no done pulse.
REQ-032 SHALL, for as long as rst is held high, keep all outputs at their reset values.

Verification
REQ-033 SHALL cover: W=3, x=011, y=010, start for 1 cycle -> busy for 3 cycles, then done=1, o=100, cycles=3.
REQ-034 SHALL cover: x=100, y=011 -> early exit after 1 cycle: done=1, o=100, cycles=1; then x=001, y=010 -> o=001, cycles=2.
REQ-035 SHALL cover: x=y=010 -> o=010, cycles=3; a second start held high in the DONE cycle -> new SHIFT begins with no IDLE gap.
REQ-036 SHALL cover: start x=000, y=000, then abort in the second SHIFT cycle -> IDLE, no done, o and cycles keep their prior values.
REQ-037 SHALL cover: start pulsed again mid-SHIFT with different x, y -> ignored; the result matches the originally latched operands.
REQ-038 SHALL cover: rst asserted mid-SHIFT -> next cycle busy=0, done=0, o=000, cycles=0, and no done pulse follows.

Source files
------------

// File: rtl/seq_cmp_ctrl.sv
// seq_cmp_ctrl: bit-serial unsigned magnitude comparator.
// One bit pair is examined per cycle, MSB first. The result {gt, eq, lt}
// and the number of bits examined are produced as soon as the first
// differing bit is found, or after the LSB when all bits match.
module seq_cmp_ctrl #(
  parameter int W  = 3,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  output logic          busy,
  output logic          done,
  output logic [2:0]    o,
  output logic [CW-1:0] cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] IDX_TOP = CW'(W - 1);
  localparam logic [CW-1:0] WIDTH_C = CW'(W);

  // One-bit relation encoded as {gt, eq, lt}; always exactly one-hot.
  function automatic logic [2:0] bit_rel(input logic a, input logic b);
    logic [2:0] r;
    if (a == b) begin
      r = 3'b010;
    end else if (a) begin
      r = 3'b100;
    end else begin
      r = 3'b001;
    end
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [W-1:0]   xa_q, xa_d;
  logic [W-1:0]   ya_q, ya_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [2:0]     o_q, o_d;
  logic [CW-1:0]  cycles_q, cycles_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [W-1:0]   x_sh_s;
  logic [W-1:0]   y_sh_s;
  logic [2:0]     rel_s;

  // Pick the bit pair at the current index and relate it.
  always_comb begin
    x_sh_s = xa_q >> idx_q;
    y_sh_s = ya_q >> idx_q;
    rel_s  = bit_rel(x_sh_s[0], y_sh_s[0]);
  end

  // Next-state, operand latch, index and result computation.
  always_comb begin
    state_d  = state_q;
    xa_d     = xa_q;
    ya_d     = ya_q;
    idx_d    = idx_q;
    o_d      = o_q;
    cycles_d = cycles_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // Abort wins over start; a DONE cycle always finishes its pulse.
        if (start && !abort) begin
          xa_d    = x;
          ya_d    = y;
          idx_d   = IDX_TOP;
          state_d = SHIFT;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Result registers are untouched on abort so the old result persists.
        if (abort) begin
          state_d = IDLE;
        end else if (rel_s != 3'b010) begin
          o_d      = rel_s;
          cycles_d = WIDTH_C - idx_q;
          state_d  = DONE;
          done_d   = 1'b1;
        end else if (idx_q == {CW{1'b0}}) begin
          o_d      = 3'b010;
          cycles_d = WIDTH_C;
          state_d  = DONE;
          done_d   = 1'b1;
        end else begin
          idx_d  = idx_q - {{(CW-1){1'b0}}, 1'b1};
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      xa_q     <= {W{1'b0}};
      ya_q     <= {W{1'b0}};
      idx_q    <= {CW{1'b0}};
      o_q      <= 3'b000;
      cycles_q <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xa_q     <= xa_d;
      ya_q     <= ya_d;
      idx_q    <= idx_d;
      o_q      <= o_d;
      cycles_q <= cycles_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign o      = o_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_seq_cmp_ctrl.sv
// Directed, table-driven bench for seq_cmp_ctrl (W=3).
module tb_seq_cmp_ctrl;

  localparam int W  = 3;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          busy;
  logic          done;
  logic [2:0]    o;
  logic [CW-1:0] cycles;

  int n_cmp;
  int n_err;

  seq_cmp_ctrl #(.W(W), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .x      (x),
    .y      (y),
    .busy   (busy),
    .done   (done),
    .o      (o),
    .cycles (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] vx;
    logic [W-1:0] vy;
    logic [2:0]   eo;
    int           ek;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at the first negedge after the start edge (or later, with lat0
  // giving the number of SHIFT cycles already elapsed). Returns at the
  // negedge where done is high.
  task automatic wait_done(input string nm, input logic [2:0] eo, input int ek, input int lat0);
    int lat;
    int bc;
    lat = lat0;
    bc  = lat0;
    while (done !== 1'b1 && lat <= W + 3) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_done_seen"}, int'(done === 1'b1), 1);
    chk({nm, "_latency"}, lat, ek);
    chk({nm, "_busy_cycles"}, bc, ek);
    chk({nm, "_o"}, int'(o), int'(eo));
    chk({nm, "_cycles"}, int'(cycles), ek);
    chk({nm, "_busy_in_done"}, int'(busy), 0);
  endtask

  task automatic run_cmp(input string nm, input logic [W-1:0] vx, input logic [W-1:0] vy,
                         input logic [2:0] eo, input int ek);
    x = vx;
    y = vy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nm, eo, ek, 0);
    @(negedge clk);
    chk({nm, "_done_drop"}, int'(done), 0);
    chk({nm, "_o_hold"}, int'(o), int'(eo));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    x     = 3'b000;
    y     = 3'b000;

    vecs[0] = '{3'b011, 3'b010, 3'b100, 3};
    vecs[1] = '{3'b100, 3'b011, 3'b100, 1};
    vecs[2] = '{3'b001, 3'b010, 3'b001, 2};
    vecs[3] = '{3'b010, 3'b010, 3'b010, 3};
    vecs[4] = '{3'b111, 3'b111, 3'b010, 3};
    vecs[5] = '{3'b000, 3'b001, 3'b001, 3};
    vecs[6] = '{3'b110, 3'b101, 3'b100, 2};
    vecs[7] = '{3'b011, 3'b111, 3'b001, 1};

    // Reset, with start requested while reset is held.
    @(negedge clk);
    start = 1'b1;
    x = 3'b100;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_o", int'(o), 0);
    chk("rst_cycles", int'(cycles), 0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);

    // Table-driven comparisons.
    for (int i = 0; i < 8; i++) begin
      run_cmp($sformatf("vec%0d", i), vecs[i].vx, vecs[i].vy, vecs[i].eo, vecs[i].ek);
    end

    // Back-to-back: start held in the DONE cycle, no IDLE gap.
    x = 3'b010; y = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_first", 3'b010, 3, 0);
    x = 3'b101; y = 3'b100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_gap_busy", int'(busy), 1);
    chk("b2b_o_held_in_shift", int'(o), 2);
    chk("b2b_cycles_held_in_shift", int'(cycles), 3);
    wait_done("b2b_second", 3'b100, 3, 0);
    @(negedge clk);
    chk("b2b_idle_after", int'(busy), 0);

    // Abort in the second SHIFT cycle: no done, result untouched (100, 3).
    x = 3'b000; y = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_o_kept", int'(o), 4);
    chk("abort_cycles_kept", int'(cycles), 3);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (done === 1'b1) seen++;
      end
      chk("abort_no_late_done", seen, 0);
    end

    // Start pulsed mid-SHIFT with different operands is ignored.
    x = 3'b011; y = 3'b011; start = 1'b1;
    @(negedge clk);
    x = 3'b100; y = 3'b000;
    @(negedge clk);
    start = 1'b0;
    x = 3'b000; y = 3'b111;
    wait_done("ignore_start", 3'b010, 3, 1);
    @(negedge clk);

    // Abort together with start in IDLE: start is ignored.
    x = 3'b100; y = 3'b000; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_busy", int'(busy), 0);
    @(negedge clk);
    chk("abort_start_idle_done", int'(done), 0);

    // Abort in DONE: pulse completes, FSM returns to IDLE.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("abort_in_done", 3'b100, 1, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_done_drop", int'(done), 0);
    chk("abort_in_done_idle", int'(busy), 0);

    // Reset mid-SHIFT clears outputs and suppresses done.
    x = 3'b000; y = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_o", int'(o), 0);
    chk("midrst_cycles", int'(cycles), 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (done === 1'b1) seen++;
      end
      chk("midrst_no_done", seen, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
